// File: rtl/uart_pkg.sv
// Shared register map, bit positions and TX sequencer states for the UART controller.
package uart_pkg;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int ST_RXNE    = 0;
    localparam int ST_RXFULL  = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_HOLD    = 3;
    localparam int ST_TXBUSY  = 4;

    localparam int CTRL_RX_EN   = 0;
    localparam int CTRL_TX_EN   = 1;
    localparam int CTRL_RXNE_IE = 2;
    localparam int CTRL_OVR_IE  = 3;

    localparam logic [13:0] DEFAULT_BAUD_DIV = 14'd5208;

    typedef enum logic [1:0] {IDLE, LAUNCH, ARM, ACTIVE} tx_state_t;

    // A zero divisor would stall the bit-rate counters, so it is forced to 1.
    function automatic logic [13:0] baud_coerce(input logic [13:0] v);
        return (v == 14'd0) ? 14'd1 : v;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [7:0]   din,
    output logic [7:0]   dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count,
    output logic         overflow
);

    logic [DEPTH-1:0][7:0] mem;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// CPU-facing UART controller: register decode, RX byte buffering, TX holding register and launch sequencer.
module uart_ctrl #(
    parameter int          RX_DEPTH         = 8,
    parameter logic [13:0] DEFAULT_BAUD_DIV = uart_pkg::DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [13:0] baudrate_reg,
    output logic        irq
);
    import uart_pkg::*;

    localparam int AW = $clog2(RX_DEPTH);

    logic [3:0]  ctrl;
    logic        overrun;
    logic        hold_full;
    logic [7:0]  hold_data;
    tx_state_t   state;

    logic        rd_req, wr_req, fifo_pop, fifo_push;
    logic [7:0]  fifo_head;
    logic        fifo_full, fifo_empty, fifo_ovf;
    logic [AW:0] fifo_count;
    logic [31:0] status_word, rd_word;
    logic        unused_wdata;

    assign rd_req       = bus_sel & ~bus_we;
    assign wr_req       = bus_sel & bus_we;
    assign fifo_pop     = rd_req && (bus_addr == UART_DATA);
    assign fifo_push    = rx_done & ctrl[CTRL_RX_EN];
    assign unused_wdata = ^bus_wdata[31:14];

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (rx_data),
        .dout     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    always_comb begin
        status_word            = '0;
        status_word[ST_RXNE]   = ~fifo_empty;
        status_word[ST_RXFULL] = fifo_full;
        status_word[ST_OVR]    = overrun;
        status_word[ST_HOLD]   = hold_full;
        status_word[ST_TXBUSY] = tx_busy;
        status_word[15:8]      = 8'(fifo_count);
    end

    always_comb begin
        rd_word = '0;
        case (bus_addr)
            UART_DATA:   rd_word = fifo_empty ? 32'd0 : {24'd0, fifo_head};
            UART_STATUS: rd_word = status_word;
            UART_BAUD:   rd_word = {18'd0, baudrate_reg};
            UART_CTRL:   rd_word = {28'd0, ctrl};
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata    <= '0;
            bus_rvalid   <= 1'b0;
            baudrate_reg <= DEFAULT_BAUD_DIV;
            ctrl         <= '0;
            overrun      <= 1'b0;
            irq          <= 1'b0;
        end else begin
            bus_rvalid <= rd_req;
            if (rd_req) bus_rdata <= rd_word;
            if (wr_req && bus_addr == UART_BAUD) baudrate_reg <= baud_coerce(bus_wdata[13:0]);
            if (wr_req && bus_addr == UART_CTRL) ctrl <= bus_wdata[3:0];
            // A fresh overrun beats a same-cycle software clear.
            if (fifo_ovf)
                overrun <= 1'b1;
            else if (wr_req && bus_addr == UART_STATUS && bus_wdata[ST_OVR])
                overrun <= 1'b0;
            irq <= (ctrl[CTRL_RXNE_IE] & ~fifo_empty) | (ctrl[CTRL_OVR_IE] & overrun);
        end
    end

    // Hold is freed on the launch edge so the CPU can queue the next byte during LAUNCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            hold_data <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (hold_full && ctrl[CTRL_TX_EN] && !tx_busy) begin
                        tx_data   <= hold_data;
                        hold_full <= 1'b0;
                        tx_start  <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH:  state <= ARM;
                ARM:     state <= ACTIVE;
                ACTIVE:  if (!tx_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (wr_req && bus_addr == UART_DATA && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= bus_wdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Randomized and directed check of uart_ctrl against a queue-based register/FIFO model.
module tb_uart_ctrl;
    import uart_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_sel = 1'b0, bus_we = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [13:0] baudrate_reg;
    logic        irq;

    always #5 clk = ~clk;

    uart_ctrl #(.RX_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .rx_done(rx_done), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .baudrate_reg(baudrate_reg), .irq(irq)
    );

    int errors = 0;
    int checks = 0;
    int n_starts = 0;

    // reference state
    logic [7:0]  q[$];
    bit          m_ovr;
    logic [13:0] m_baud;
    logic [3:0]  m_ctrl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_ovr  = 0;
        m_baud = 14'd5208;
        m_ctrl = '0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        bus_sel = 1'b0; rx_done = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_rvalid", bus_rvalid, 0);
        check("rst_rdata", bus_rdata, 0);
        check("rst_txstart", tx_start, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_irq", irq, 0);
        check("rst_baud", baudrate_reg, 5208);
        reset = 1'b0;
        m_reset();
    endtask

    // One bus/receiver cycle; model is advanced from the pre-edge state.
    task automatic step(input bit sel, input bit we, input logic [1:0] addr,
                        input logic [31:0] wd, input bit rxd, input logic [7:0] rxb);
        logic [31:0] exp_rd, mask;
        bit is_rd, popping, ovr_set, exp_irq;
        int n;
        bus_sel = sel; bus_we = we; bus_addr = addr; bus_wdata = wd;
        rx_done = rxd; rx_data = rxb;
        n       = q.size();
        is_rd   = sel && !we;
        exp_irq = (m_ctrl[2] && n > 0) || (m_ctrl[3] && m_ovr);
        mask    = 32'hFFFF_FFFF;
        case (addr)
            2'd0:    exp_rd = (n > 0) ? {24'd0, q[0]} : 32'd0;
            2'd1: begin
                exp_rd = {16'd0, 8'(n), 3'd0, tx_busy, 1'b0, m_ovr, (n == DEPTH), (n > 0)};
                if (m_ctrl[1]) mask[3] = 1'b0;
            end
            2'd2:    exp_rd = {18'd0, m_baud};
            default: exp_rd = {28'd0, m_ctrl};
        endcase
        popping = is_rd && addr == 2'd0 && n > 0;
        ovr_set = 0;
        if (popping) void'(q.pop_front());
        if (rxd && m_ctrl[0]) begin
            if (n == DEPTH && !popping) ovr_set = 1;
            else q.push_back(rxb);
        end
        if (ovr_set) m_ovr = 1;
        else if (sel && we && addr == 2'd1 && wd[2]) m_ovr = 0;
        if (sel && we && addr == 2'd2) m_baud = (wd[13:0] == 14'd0) ? 14'd1 : wd[13:0];
        if (sel && we && addr == 2'd3) m_ctrl = wd[3:0];
        @(posedge clk);
        #1;
        bus_sel = 1'b0; bus_we = 1'b0; rx_done = 1'b0;
        if (tx_start === 1'b1) n_starts++;
        check("rvalid", bus_rvalid, is_rd);
        if (is_rd) check($sformatf("rdata_a%0d", addr), bus_rdata & mask, exp_rd & mask);
        check("irq", irq, exp_irq);
        check("baudrate_reg", baudrate_reg, m_baud);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d); step(1, 1, a, d, 0, 0); endtask
    task automatic rd(input logic [1:0] a);                       step(1, 0, a, 0, 0, 0); endtask
    task automatic rx(input logic [7:0] b);                       step(0, 0, 0, 0, 1, b); endtask
    task automatic idle();                                        step(0, 0, 0, 0, 0, 0); endtask

    initial begin
        int s0, k;
        bit got;
        m_reset();
        do_reset(2);

        // reset register contents
        rd(UART_BAUD);   check("baud_reset", bus_rdata, 5208);
        rd(UART_STATUS); check("status_reset", bus_rdata, 0);

        // basic receive path
        wr(UART_CTRL, 32'h1);
        rx(8'h41); rx(8'h42);
        rd(UART_DATA); check("rx_first", bus_rdata, 32'h41);
        rd(UART_DATA); check("rx_second", bus_rdata, 32'h42);
        rd(UART_DATA); check("rx_empty", bus_rdata, 0);
        rd(UART_STATUS); check("rxne_clear", bus_rdata[0], 0);

        // overrun and full-FIFO behaviour
        wr(UART_CTRL, 32'h9);
        for (int i = 0; i < 9; i++) rx(8'h10 + 8'(i));
        idle();
        rd(UART_STATUS);
        check("full_count", bus_rdata[15:8], 8);
        check("full_flag", bus_rdata[1], 1);
        check("ovr_flag", bus_rdata[2], 1);
        check("ovr_irq", irq, 1);
        rd(UART_DATA); check("full_head", bus_rdata, 32'h10);
        wr(UART_STATUS, 32'h4);
        idle(); check("irq_drop", irq, 0);
        rx(8'h19);
        step(1, 0, UART_DATA, 0, 1, 8'h1A); check("popush_data", bus_rdata, 32'h11);
        rd(UART_STATUS);
        check("popush_count", bus_rdata[15:8], 8);
        check("popush_ovr", bus_rdata[2], 0);

        // randomized register/FIFO traffic with the transmitter disabled
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            tx_busy = 1'($urandom);
            if (r < 5)       wr(UART_CTRL, $urandom & 32'hD);
            else if (r < 10) wr(UART_STATUS, $urandom);
            else if (r < 15) wr(UART_BAUD, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            else step(1'($urandom_range(0, 1)), 1'b0, 2'($urandom), 0,
                      ($urandom_range(0, 99) < 45), 8'($urandom));
        end
        tx_busy = 1'b0;

        // transmit sequencing
        do_reset(1);
        wr(UART_CTRL, 32'h2);
        wr(UART_DATA, 32'h55); check("tx_wait", tx_start, 0);
        idle();
        check("tx_start1", tx_start, 1);
        check("tx_data1", tx_data, 8'h55);
        tx_busy = 1'b1;
        idle(); check("tx_pulse1", tx_start, 0);
        s0 = n_starts;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) wr(UART_DATA, 32'hAA);
            else if (i == 5) begin rd(UART_STATUS); check("hold_full", bus_rdata[3], 1); end
            else if (i == 7) wr(UART_DATA, 32'h77);
            else idle();
        end
        check("no_start_busy", n_starts, s0);
        check("tx_data_stable", tx_data, 8'h55);
        tx_busy = 1'b0;
        got = 0; k = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            idle(); k++;
            if (tx_start === 1'b1) got = 1;
        end
        check("tx_start2", got, 1);
        check("tx_start2_lat", k, 2);
        check("tx_data2", tx_data, 8'hAA);
        s0 = n_starts;
        tx_busy = 1'b1;
        repeat (5) idle();
        tx_busy = 1'b0;
        repeat (10) idle();
        check("third_discarded", n_starts, s0);

        // baud divisor edges
        wr(UART_BAUD, 32'h0);
        rd(UART_BAUD); check("baud_zero", bus_rdata, 1);
        wr(UART_BAUD, 32'h3FFF);
        idle(); check("baud_max", baudrate_reg, 16383);

        // reset in the middle of a transfer with queued receive data
        wr(UART_CTRL, 32'h7);
        wr(UART_BAUD, 32'd100);
        rx(8'hA1); rx(8'hA2); rx(8'hA3);
        wr(UART_DATA, 32'h33);
        idle(); check("pre_rst_start", tx_start, 1);
        tx_busy = 1'b1;
        idle(); idle();
        check("pre_rst_irq", irq, 1);
        do_reset(1);
        tx_busy = 1'b0;
        rd(UART_STATUS); check("post_rst_status", bus_rdata, 0);
        s0 = n_starts;
        repeat (4) idle();
        check("post_rst_idle", n_starts, s0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
